// File: rtl/sample_scheduler.sv
// Sample scheduler: accepts one bounding-boxed triangle and walks its box on the subsample
// grid in raster order, emitting SAMPLES horizontally adjacent sample positions per cycle.
module sample_scheduler #(
    parameter int SIGFIG  = 24,
    parameter int RADIX   = 10,
    parameter int VERTS   = 3,
    parameter int AXIS    = 3,
    parameter int COLORS  = 3,
    parameter int SAMPLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S       [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R13U     [COLORS],
    input  logic signed [SIGFIG-1:0] box_R13S       [2][2],
    input  logic                     validTri_R13H,
    input  logic        [3:0]        subSample_RnnU,
    output logic                     halt_R13L,
    input  logic                     halt_R16L,
    output logic signed [SIGFIG-1:0] tri_R16S       [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R16U     [COLORS],
    output logic signed [SIGFIG-1:0] sample_R16S    [SAMPLES][2],
    output logic        [SAMPLES-1:0] validSamp_R16H
);

    // One extra bit so position sums can never wrap into range.
    typedef logic signed [SIGFIG:0] wide_t;
    typedef enum logic {StWait, StTest} state_t;

    state_t                   state_q;
    logic signed [SIGFIG-1:0] cur_x_q, cur_y_q;
    logic signed [SIGFIG-1:0] ll_x_q, ur_x_q, ur_y_q;
    logic signed [SIGFIG-1:0] step_q;
    logic                     empty_q;

    logic signed [SIGFIG-1:0] acc_step;
    logic                     accept;

    wide_t end_x, next_y, base_x, base_y, g_step, g_ur_x, g_ur_y, lx;
    logic  row_end, done;
    logic signed [SIGFIG-1:0] grp_x [SAMPLES];
    logic        [SAMPLES-1:0] grp_v;

    function automatic wide_t sext(input logic [SIGFIG-1:0] v);
        return {v[SIGFIG-1], v};
    endfunction

    assign halt_R13L = (state_q == StWait) && halt_R16L;
    assign accept    = validTri_R13H && halt_R13L;

    // Anything that is not a clean one-hot falls back to 1x.
    always_comb begin
        case (subSample_RnnU)
            4'b0100: acc_step = SIGFIG'(1) << (RADIX - 1);
            4'b0010: acc_step = SIGFIG'(1) << (RADIX - 2);
            4'b0001: acc_step = SIGFIG'(1) << (RADIX - 3);
            default: acc_step = SIGFIG'(1) << RADIX;
        endcase
    end

    // Next group: from the incoming box when idle, otherwise the raster successor of cur.
    always_comb begin
        end_x = sext(cur_x_q);
        for (int i = 0; i < SAMPLES; i++) begin
            end_x = end_x + sext(step_q);
        end
        next_y  = sext(cur_y_q) + sext(step_q);
        row_end = end_x > sext(ur_x_q);
        done    = empty_q || (row_end && (next_y > sext(ur_y_q)));

        if (state_q == StWait) begin
            base_x = sext(box_R13S[0][0]);
            base_y = sext(box_R13S[0][1]);
            g_step = sext(acc_step);
            g_ur_x = sext(box_R13S[1][0]);
            g_ur_y = sext(box_R13S[1][1]);
        end else begin
            base_x = row_end ? sext(ll_x_q) : end_x;
            base_y = row_end ? next_y : sext(cur_y_q);
            g_step = sext(step_q);
            g_ur_x = sext(ur_x_q);
            g_ur_y = sext(ur_y_q);
        end

        lx = base_x;
        for (int i = 0; i < SAMPLES; i++) begin
            grp_x[i] = lx[SIGFIG-1:0];
            grp_v[i] = (lx <= g_ur_x) && (base_y <= g_ur_y);
            lx       = lx + g_step;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StWait;
            cur_x_q        <= '0;
            cur_y_q        <= '0;
            ll_x_q         <= '0;
            ur_x_q         <= '0;
            ur_y_q         <= '0;
            step_q         <= SIGFIG'(1) << RADIX;
            empty_q        <= 1'b0;
            validSamp_R16H <= '0;
            for (int v = 0; v < VERTS; v++) begin
                for (int a = 0; a < AXIS; a++) begin
                    tri_R16S[v][a] <= '0;
                end
            end
            for (int c = 0; c < COLORS; c++) begin
                color_R16U[c] <= '0;
            end
            for (int i = 0; i < SAMPLES; i++) begin
                sample_R16S[i][0] <= '0;
                sample_R16S[i][1] <= '0;
            end
        end else if (state_q == StWait) begin
            if (accept) begin
                state_q    <= StTest;
                tri_R16S   <= tri_R13S;
                color_R16U <= color_R13U;
                ll_x_q     <= box_R13S[0][0];
                ur_x_q     <= box_R13S[1][0];
                ur_y_q     <= box_R13S[1][1];
                step_q     <= acc_step;
                empty_q    <= (box_R13S[1][0] < box_R13S[0][0]) ||
                              (box_R13S[1][1] < box_R13S[0][1]);
                cur_x_q    <= base_x[SIGFIG-1:0];
                cur_y_q    <= base_y[SIGFIG-1:0];
                validSamp_R16H <= grp_v;
                for (int i = 0; i < SAMPLES; i++) begin
                    sample_R16S[i][0] <= grp_x[i];
                    sample_R16S[i][1] <= base_y[SIGFIG-1:0];
                end
            end
        end else if (halt_R16L) begin
            if (done) begin
                state_q        <= StWait;
                validSamp_R16H <= '0;
            end else begin
                cur_x_q        <= base_x[SIGFIG-1:0];
                cur_y_q        <= base_y[SIGFIG-1:0];
                validSamp_R16H <= grp_v;
                for (int i = 0; i < SAMPLES; i++) begin
                    sample_R16S[i][0] <= grp_x[i];
                    sample_R16S[i][1] <= base_y[SIGFIG-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_sample_scheduler.sv
// Directed bench for sample_scheduler (SAMPLES=2) with hand-computed sample groups.
module tb_sample_scheduler;

    localparam int SIGFIG  = 24;
    localparam int VERTS   = 3;
    localparam int AXIS    = 3;
    localparam int COLORS  = 3;
    localparam int SAMPLES = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic signed [SIGFIG-1:0] tri_R13S       [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R13U     [COLORS];
    logic signed [SIGFIG-1:0] box_R13S       [2][2];
    logic                     validTri_R13H;
    logic        [3:0]        subSample_RnnU;
    logic                     halt_R13L;
    logic                     halt_R16L;
    logic signed [SIGFIG-1:0] tri_R16S       [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R16U     [COLORS];
    logic signed [SIGFIG-1:0] sample_R16S    [SAMPLES][2];
    logic        [SAMPLES-1:0] validSamp_R16H;

    int total = 0;
    int bad   = 0;
    int nvalid;

    sample_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .tri_R13S       (tri_R13S),
        .color_R13U     (color_R13U),
        .box_R13S       (box_R13S),
        .validTri_R13H  (validTri_R13H),
        .subSample_RnnU (subSample_RnnU),
        .halt_R13L      (halt_R13L),
        .halt_R16L      (halt_R16L),
        .tri_R16S       (tri_R16S),
        .color_R16U     (color_R16U),
        .sample_R16S    (sample_R16S),
        .validSamp_R16H (validSamp_R16H)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic int wrap24(input int v);
        logic signed [23:0] t;
        t = v[23:0];
        return int'(t);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tally();
        if (halt_R16L) nvalid += $countones(validSamp_R16H);
    endtask

    task automatic expect_grp(input string tag, input int x0, input int y, input int stp,
                              input logic [1:0] v);
        check_eq({tag, ".x0"}, sample_R16S[0][0], x0);
        check_eq({tag, ".x1"}, sample_R16S[1][0], wrap24(x0 + stp));
        check_eq({tag, ".y0"}, sample_R16S[0][1], y);
        check_eq({tag, ".y1"}, sample_R16S[1][1], y);
        check_eq({tag, ".v"}, validSamp_R16H, v);
    endtask

    // Presents a triangle and returns one step after the accepting edge.
    task automatic present(input int id, input int llx, input int lly, input int urx,
                           input int ury, input logic [3:0] ss);
        bit ok = 1'b0;
        for (int v = 0; v < VERTS; v++) begin
            for (int a = 0; a < AXIS; a++) begin
                tri_R13S[v][a] = SIGFIG'(id * 16 + v * 3 + a);
            end
        end
        for (int c = 0; c < COLORS; c++) color_R13U[c] = SIGFIG'(id * 32 + c);
        box_R13S[0][0] = SIGFIG'(llx);
        box_R13S[0][1] = SIGFIG'(lly);
        box_R13S[1][0] = SIGFIG'(urx);
        box_R13S[1][1] = SIGFIG'(ury);
        subSample_RnnU = ss;
        validTri_R13H  = 1'b1;
        #0;
        for (int n = 0; n < 20 && !ok; n++) begin
            if (halt_R13L) ok = 1'b1;
            tick();
        end
        validTri_R13H = 1'b0;
        if (!ok) check_eq("accept_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        halt_R16L = 1'b1;
        validTri_R13H = 1'b0;
        subSample_RnnU = 4'b1000;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++) tri_R13S[v][a] = '0;
        for (int c = 0; c < COLORS; c++) color_R13U[c] = '0;
        for (int i = 0; i < 2; i++) begin
            box_R13S[i][0] = '0;
            box_R13S[i][1] = '0;
        end
        #2 rst = 1'b0;
        tick();
        check_eq("rst.valid", validSamp_R16H, 0);
        check_eq("rst.halt13", halt_R13L, 1);
        check_eq("rst.sx", sample_R16S[1][0], 0);
        check_eq("rst.tri", tri_R16S[2][2], 0);
        check_eq("rst.color", color_R16U[1], 0);
        rst = 1'b1;
        tick();

        // 1x, ur=(2048,1024): four groups then a bubble
        present(1, 0, 0, 2048, 1024, 4'b1000);
        check_eq("t1.tri", tri_R16S[2][1], 1 * 16 + 7);
        check_eq("t1.color", color_R16U[2], 1 * 32 + 2);
        check_eq("t1.halt13_busy", halt_R13L, 0);
        expect_grp("t1.g1", 0, 0, 1024, 2'b11);
        tick(); expect_grp("t1.g2", 2048, 0, 1024, 2'b01);
        tick(); expect_grp("t1.g3", 0, 1024, 1024, 2'b11);
        tick(); expect_grp("t1.g4", 2048, 1024, 1024, 2'b01);
        tick();
        check_eq("t1.bubble_v", validSamp_R16H, 0);
        check_eq("t1.bubble_halt13", halt_R13L, 1);
        check_eq("t1.hold_x", sample_R16S[0][0], 2048);
        tick();

        // Same box with a 3-cycle stall on group 2
        nvalid = 0;
        present(2, 0, 0, 2048, 1024, 4'b1000);
        expect_grp("st.g1", 0, 0, 1024, 2'b11); tally();
        tick(); expect_grp("st.g2", 2048, 0, 1024, 2'b01);
        halt_R16L = 1'b0;
        tally();
        for (int k = 0; k < 2; k++) begin
            tick();
            expect_grp("st.frozen", 2048, 0, 1024, 2'b01);
            check_eq("st.halt13", halt_R13L, 0);
        end
        tick(); expect_grp("st.frozen_last", 2048, 0, 1024, 2'b01);
        halt_R16L = 1'b1;
        tally();
        tick(); expect_grp("st.g3", 0, 1024, 1024, 2'b11); tally();
        tick(); expect_grp("st.g4", 2048, 1024, 1024, 2'b01); tally();
        tick();
        check_eq("st.bubble_v", validSamp_R16H, 0);
        check_eq("st.nvalid", nvalid, 6);
        tick();

        // 4x, then a second triangle offered in the bubble
        present(3, 0, 0, 512, 512, 4'b0100);
        expect_grp("q.g1", 0, 0, 512, 2'b11);
        tick(); expect_grp("q.g2", 0, 512, 512, 2'b11);
        tick();
        check_eq("q.bubble_v", validSamp_R16H, 0);
        check_eq("q.bubble_halt13", halt_R13L, 1);
        present(4, 0, 0, 1024, 0, 4'b1000);
        expect_grp("b2b.g1", 0, 0, 1024, 2'b11);
        check_eq("b2b.tri", tri_R16S[0][0], 4 * 16);
        tick();
        check_eq("b2b.bubble_v", validSamp_R16H, 0);
        tick();

        // Empty box: one dead TEST cycle then idle
        present(5, 1024, 0, 0, 0, 4'b1000);
        check_eq("e.v1", validSamp_R16H, 0);
        check_eq("e.halt13_busy", halt_R13L, 0);
        tick();
        check_eq("e.v2", validSamp_R16H, 0);
        check_eq("e.halt13_idle", halt_R13L, 1);
        tick();

        // Top of the positive range: lane1 must not wrap into validity
        present(6, 8387584, 0, 8387584, 0, 4'b1000);
        expect_grp("ov.g1", 8387584, 0, 1024, 2'b01);
        tick();
        check_eq("ov.done_v", validSamp_R16H, 0);
        check_eq("ov.done_halt13", halt_R13L, 1);
        tick();

        // Reset during row 2 of a 4x triangle
        present(7, 0, 0, 512, 512, 4'b0100);
        tick(); expect_grp("r.g2", 0, 512, 512, 2'b11);
        rst = 1'b0;
        #1;
        check_eq("r.v", validSamp_R16H, 0);
        check_eq("r.halt13", halt_R13L, 1);
        check_eq("r.sx", sample_R16S[0][1], 0);
        check_eq("r.tri", tri_R16S[1][1], 0);
        #2 rst = 1'b1;
        tick();
        present(8, 2048, 1024, 3072, 1024, 4'b1000);
        expect_grp("r2.g1", 2048, 1024, 1024, 2'b11);
        check_eq("r2.color", color_R16U[0], 8 * 32);
        tick();
        check_eq("r2.bubble_v", validSamp_R16H, 0);
        check_eq("r2.halt13", halt_R13L, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
